pic24_icsp_target: RTL and testbench

PIC24 ICSP target-side responder: the device end of the 2-wire PGC/PGD link driven by pic24programmer.
- Oversamples PGCx, PGDx_in and MCLRn on clk50MHz.
- Validates the 32-bit ICSP entry key, then decodes SIX (execute instruction) and REGOUT (read VISI) commands.
- On REGOUT, drives VISI data back onto PGD.
- Serves as on-FPGA loopback partner and bench model for the programmer.

---
 rtl/pic24_icsp_target.sv | 214 +++++++++++++++++++++
 tb/tb_pic24_icsp_target.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pic24_icsp_target.sv
// PIC24 ICSP target-side responder: validates the entry key, then decodes SIX and
// REGOUT commands clocked in on PGC, returning VISI data on PGD.
module pic24_icsp_target #(
  parameter logic [31:0] ENTRY_KEY   = 32'h4D434851,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk50MHz,
  input  logic        rst,
  input  logic        MCLRn,
  input  logic        PGCx,
  input  logic        PGDx_in,
  output logic        PGDx_out,
  output logic        PGDx_oe,
  output logic        icsp_active,
  output logic        six_valid,
  output logic [23:0] six_instr,
  input  logic [15:0] visi_data,
  output logic        regout_done,
  output logic        key_error,
  output logic        bad_cmd
);

  typedef enum logic [2:0] {
    S_IDLE, S_KEY, S_LOCKED, S_WAIT_MCLR, S_CMD, S_SIX, S_PAD, S_RDATA
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] pgc_sync_q, pgc_sync_d;
  logic [SYNC_STAGES-1:0] pgd_sync_q, pgd_sync_d;
  logic [SYNC_STAGES-1:0] mclr_sync_q, mclr_sync_d;
  logic                   pgc_prev_q, mclr_prev_q, armed_q, armed_d;
  logic [4:0]             cnt_q, cnt_d;
  logic [31:0]            sh_q, sh_d;
  logic [15:0]            rd_q, rd_d;
  logic [23:0]            six_instr_q, six_instr_d;
  logic                   pgd_out_q, pgd_out_d, pgd_oe_q, pgd_oe_d;
  logic                   active_q, active_d;
  logic                   six_valid_q, six_valid_d, done_q, done_d;
  logic                   kerr_q, kerr_d, bad_q, bad_d;

  logic        pgc_s, pgd_s, mclr_s, rise, fall, mclr_rise, mclr_fall, abort;
  logic [31:0] sh_msb;
  logic [23:0] sh_lsb;

  always_comb begin
    pgc_sync_d  = {pgc_sync_q[SYNC_STAGES-2:0], PGCx};
    pgd_sync_d  = {pgd_sync_q[SYNC_STAGES-2:0], PGDx_in};
    mclr_sync_d = {mclr_sync_q[SYNC_STAGES-2:0], MCLRn};
    pgc_s       = pgc_sync_q[SYNC_STAGES-1];
    pgd_s       = pgd_sync_q[SYNC_STAGES-1];
    mclr_s      = mclr_sync_q[SYNC_STAGES-1];
    rise        = pgc_s & ~pgc_prev_q;
    fall        = ~pgc_s & pgc_prev_q;
    mclr_rise   = mclr_s & ~mclr_prev_q;
    mclr_fall   = ~mclr_s & mclr_prev_q;
    sh_msb      = {sh_q[30:0], pgd_s};
    sh_lsb      = {pgd_s, sh_q[23:1]};
    // In WAIT_MCLR the line is already low from key entry, so only a fresh fall aborts.
    abort = (~mclr_s && (state_q inside {S_CMD, S_SIX, S_PAD, S_RDATA})) ||
            (mclr_fall && state_q == S_WAIT_MCLR);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    rd_d        = rd_q;
    six_instr_d = six_instr_q;
    pgd_out_d   = pgd_out_q;
    pgd_oe_d    = pgd_oe_q;
    six_valid_d = 1'b0;
    done_d      = 1'b0;
    kerr_d      = 1'b0;
    bad_d       = 1'b0;
    armed_d     = fall ? 1'b1 : (rise ? 1'b0 : armed_q);

    if (abort) begin
      state_d   = S_KEY;
      cnt_d     = '0;
      sh_d      = '0;
      pgd_out_d = 1'b0;
      pgd_oe_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: if (!mclr_s) begin
          state_d = S_KEY;
          cnt_d   = '0;
          sh_d    = '0;
        end
        S_KEY: if (fall) begin
          sh_d  = sh_msb;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            if (sh_msb == ENTRY_KEY) state_d = S_WAIT_MCLR;
            else begin
              kerr_d  = 1'b1;
              state_d = S_LOCKED;
            end
          end
        end
        S_LOCKED: if (mclr_rise) state_d = S_IDLE;
        S_WAIT_MCLR: if (mclr_rise) begin
          state_d = S_CMD;
          cnt_d   = '0;
          sh_d    = '0;
        end
        S_CMD: if (fall) begin
          sh_d  = {8'h00, sh_lsb};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd3) begin
            cnt_d = '0;
            sh_d  = '0;
            case (sh_lsb[23:20])
              4'b0000: state_d = S_SIX;
              4'b0001: state_d = S_PAD;
              default: bad_d   = 1'b1;
            endcase
          end
        end
        S_SIX: if (fall) begin
          sh_d  = {8'h00, sh_lsb};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd23) begin
            six_instr_d = sh_lsb;
            six_valid_d = 1'b1;
            state_d     = S_CMD;
            cnt_d       = '0;
            sh_d        = '0;
          end
        end
        S_PAD: if (fall) begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd7) begin
            rd_d    = visi_data;
            state_d = S_RDATA;
            cnt_d   = '0;
          end
        end
        S_RDATA: begin
          if (rise && armed_q) begin
            pgd_oe_d  = 1'b1;
            pgd_out_d = rd_q[0];
          end
          if (fall) begin
            rd_d  = {1'b0, rd_q[15:1]};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd15) begin
              pgd_oe_d  = 1'b0;
              pgd_out_d = 1'b0;
              done_d    = 1'b1;
              state_d   = S_CMD;
              cnt_d     = '0;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    active_d = state_d inside {S_CMD, S_SIX, S_PAD, S_RDATA};
  end

  // MCLRn synchronizer resets to the idle-high level so reset release is not seen as entry.
  always_ff @(posedge clk50MHz or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pgc_sync_q  <= '0;
      pgd_sync_q  <= '0;
      mclr_sync_q <= '1;
      pgc_prev_q  <= 1'b0;
      mclr_prev_q <= 1'b1;
      armed_q     <= 1'b0;
      cnt_q       <= '0;
      sh_q        <= '0;
      rd_q        <= '0;
      six_instr_q <= '0;
      pgd_out_q   <= 1'b0;
      pgd_oe_q    <= 1'b0;
      active_q    <= 1'b0;
      six_valid_q <= 1'b0;
      done_q      <= 1'b0;
      kerr_q      <= 1'b0;
      bad_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pgc_sync_q  <= pgc_sync_d;
      pgd_sync_q  <= pgd_sync_d;
      mclr_sync_q <= mclr_sync_d;
      pgc_prev_q  <= pgc_s;
      mclr_prev_q <= mclr_s;
      armed_q     <= armed_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      rd_q        <= rd_d;
      six_instr_q <= six_instr_d;
      pgd_out_q   <= pgd_out_d;
      pgd_oe_q    <= pgd_oe_d;
      active_q    <= active_d;
      six_valid_q <= six_valid_d;
      done_q      <= done_d;
      kerr_q      <= kerr_d;
      bad_q       <= bad_d;
    end
  end

  assign PGDx_out    = pgd_out_q;
  assign PGDx_oe     = pgd_oe_q;
  assign icsp_active = active_q;
  assign six_valid   = six_valid_q;
  assign six_instr   = six_instr_q;
  assign regout_done = done_q;
  assign key_error   = kerr_q;
  assign bad_cmd     = bad_q;

endmodule

// File: tb/tb_pic24_icsp_target.sv
// Directed bench for pic24_icsp_target acting as the programmer; SIX results and
// REGOUT bits are queued when driven and checked when the target produces them.
module tb_pic24_icsp_target;

  localparam logic [31:0] KEY = 32'h4D434851;

  logic        clk50MHz = 1'b0;
  logic        rst, MCLRn, PGCx, PGDx_in;
  logic        PGDx_out, PGDx_oe, icsp_active, six_valid, regout_done, key_error, bad_cmd;
  logic [23:0] six_instr;
  logic [15:0] visi_data;

  int   n_assert = 0;
  int   n_fail   = 0;
  int   six_cnt  = 0;
  int   done_cnt = 0;
  int   kerr_cnt = 0;
  int   bad_cnt  = 0;
  int   oe_viol  = 0;
  bit   read_window = 1'b0;
  logic [23:0] six_q[$];
  logic        exp_bits[$];

  pic24_icsp_target #(.ENTRY_KEY(KEY), .SYNC_STAGES(2)) dut (
    .clk50MHz(clk50MHz), .rst(rst), .MCLRn(MCLRn), .PGCx(PGCx), .PGDx_in(PGDx_in),
    .PGDx_out(PGDx_out), .PGDx_oe(PGDx_oe), .icsp_active(icsp_active),
    .six_valid(six_valid), .six_instr(six_instr), .visi_data(visi_data),
    .regout_done(regout_done), .key_error(key_error), .bad_cmd(bad_cmd)
  );

  always #10 clk50MHz = ~clk50MHz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) @(negedge clk50MHz);
  endtask

  task automatic pgc_bit(input logic b);
    PGDx_in = b;
    PGCx = 1'b1;
    clocks(6);
    PGCx = 1'b0;
    clocks(6);
  endtask

  task automatic send_lsb(input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) pgc_bit(v[i]);
  endtask

  task automatic send_key(input logic [31:0] k);
    MCLRn = 1'b0;
    clocks(5);
    for (int i = 31; i >= 0; i--) pgc_bit(k[i]);
    clocks(4);
  endtask

  task automatic six(input logic [23:0] v, input bit expect_valid);
    if (expect_valid) six_q.push_back(v);
    send_lsb(32'h0, 4);
    send_lsb(32'(v), 24);
    clocks(4);
  endtask

  task automatic read_bits(input int n);
    logic b;
    for (int i = 0; i < n; i++) begin
      PGCx = 1'b1;
      clocks(6);
      check("rd_pending", 32'(exp_bits.size() > 0), 32'd1);
      b = (exp_bits.size() > 0) ? exp_bits.pop_front() : 1'bx;
      check("rd_bit", 32'(PGDx_out), 32'(b));
      check("rd_oe", 32'(PGDx_oe), 32'd1);
      PGCx = 1'b0;
      clocks(6);
    end
  endtask

  task automatic regout_prefix(input logic [15:0] v);
    visi_data = v;
    send_lsb(32'h1, 4);
    send_lsb(32'h0, 8);
    check("pad_oe", 32'(PGDx_oe), 32'd0);
  endtask

  always @(negedge clk50MHz) begin
    if (!rst) begin
      if (six_valid) begin
        six_cnt++;
        check("six_pending", 32'(six_q.size() > 0), 32'd1);
        if (six_q.size() > 0) check("six_instr", 32'(six_instr), 32'(six_q.pop_front()));
      end
      if (regout_done) done_cnt++;
      if (key_error) kerr_cnt++;
      if (bad_cmd) bad_cnt++;
      if (PGDx_oe && !read_window) oe_viol++;
    end
  end

  initial begin
    rst = 1'b1; MCLRn = 1'b1; PGCx = 1'b0; PGDx_in = 1'b0; visi_data = '0;
    clocks(3);
    check("reset_outputs", 32'({PGDx_out, PGDx_oe, icsp_active, six_valid, regout_done,
                                key_error, bad_cmd, six_instr}), 32'd0);
    rst = 1'b0;
    clocks(5);
    check("idle_active", 32'(icsp_active), 32'd0);

    send_key(KEY);
    check("entry_kerr", 32'(kerr_cnt), 32'd0);
    check("wait_active", 32'(icsp_active), 32'd0);
    MCLRn = 1'b1;
    clocks(6);
    check("entry_active", 32'(icsp_active), 32'd1);

    six(24'h040200, 1'b1);
    check("six1_cnt", 32'(six_cnt), 32'd1);
    check("six1_hold", 32'(six_instr), 32'h040200);

    regout_prefix(16'hA5C3);
    for (int i = 0; i < 16; i++) exp_bits.push_back(i[0] ? 1'b0 : 1'b0);
    exp_bits.delete();
    begin
      logic [15:0] v;
      v = 16'hA5C3;
      for (int i = 0; i < 16; i++) exp_bits.push_back(v[i]);
    end
    read_window = 1'b1;
    read_bits(16);
    clocks(4);
    read_window = 1'b0;
    check("regout_done", 32'(done_cnt), 32'd1);
    check("regout_oe_off", 32'(PGDx_oe), 32'd0);
    check("regout_active", 32'(icsp_active), 32'd1);

    send_lsb(32'h5, 4);
    clocks(4);
    check("bad_cmd", 32'(bad_cnt), 32'd1);
    six(24'hFFFFFF, 1'b1);
    check("six2_cnt", 32'(six_cnt), 32'd2);
    check("six2_hold", 32'(six_instr), 32'hFFFFFF);

    send_key(32'h4D434850);
    check("badkey_err", 32'(kerr_cnt), 32'd1);
    check("badkey_active", 32'(icsp_active), 32'd0);
    six(24'h000123, 1'b0);
    MCLRn = 1'b1;
    clocks(6);
    six(24'h000456, 1'b0);
    check("locked_six", 32'(six_cnt), 32'd2);
    send_key(KEY);
    MCLRn = 1'b1;
    clocks(6);
    check("reentry_active", 32'(icsp_active), 32'd1);
    six(24'h123456, 1'b1);
    check("six3_cnt", 32'(six_cnt), 32'd3);

    begin
      logic [15:0] v;
      v = 16'h3C5A;
      regout_prefix(v);
      for (int i = 0; i < 6; i++) exp_bits.push_back(v[i]);
    end
    read_window = 1'b1;
    read_bits(6);
    PGCx = 1'b1;
    clocks(2);
    MCLRn = 1'b0;
    clocks(4);
    check("abort_oe", 32'(PGDx_oe), 32'd0);
    check("abort_active", 32'(icsp_active), 32'd0);
    read_window = 1'b0;
    clocks(4);
    check("abort_no_done", 32'(done_cnt), 32'd1);
    send_key(KEY);
    MCLRn = 1'b1;
    clocks(6);
    check("post_abort_active", 32'(icsp_active), 32'd1);

    send_lsb(32'h0, 4);
    send_lsb(32'hABCDEF, 10);
    @(negedge clk50MHz);
    rst = 1'b1;
    #1;
    check("rst_outputs", 32'({PGDx_out, PGDx_oe, icsp_active, six_valid, regout_done,
                              key_error, bad_cmd}), 32'd0);
    check("rst_six_instr", 32'(six_instr), 32'd0);
    clocks(2);
    rst = 1'b0;
    clocks(4);

    check("six_queue_empty", 32'(six_q.size()), 32'd0);
    check("bit_queue_empty", 32'(exp_bits.size()), 32'd0);
    check("six_total", 32'(six_cnt), 32'd3);
    check("done_total", 32'(done_cnt), 32'd1);
    check("bad_total", 32'(bad_cnt), 32'd1);
    check("kerr_total", 32'(kerr_cnt), 32'd1);
    check("oe_outside_read", 32'(oe_viol), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
